// File: rtl/gb_joypad_pkg.sv
// Shared constants and types for the Game Boy joypad register block.
// The debounced vector order is {Start, Select, B, A, Down, Up, Left, Right}.
package gb_joypad_pkg;

  localparam logic [15:0] JOYP_ADDR  = 16'hFF00;
  localparam logic [7:0]  JOYP_RESET = 8'hCF;

  // Bit positions of the Game Boy-relevant buttons in the SNES controller word.
  localparam int unsigned BTN_B      = 0;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;
  localparam int unsigned BTN_A      = 8;

  typedef logic [7:0] btn_vec_t;

endpackage

// File: rtl/gb_debounce.sv
// One button line: two-flop synchroniser followed by a stability counter.
// The stable level only follows the input after DEBOUNCE_CYCLES unchanged cycles.
module gb_debounce #(
  parameter int DEBOUNCE_CYCLES = 16384,
  parameter int CNT_W           = 15
) (
  input  logic cpu_clock,
  input  logic rst,
  input  logic raw_in,
  output logic stable_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every _d gets a default before any branch, so no path can infer a latch.
  always_comb begin
    sync1_d  = raw_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge cpu_clock) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_out = stable_q;

endmodule

// File: rtl/gb_joypad_regs.sv
// JOYP register at 0xFF00: select bits, button-matrix readback and the
// joypad interrupt pulse on any falling readback line.
module gb_joypad_regs
  import gb_joypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16384,
  parameter int CNT_W           = 15
) (
  input  logic        cpu_clock,
  input  logic        rst,
  input  logic [15:0] snes_buttons,
  input  logic [15:0] cpu_addr_bus,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_we,
  output logic        hit,
  output logic [7:0]  data_out,
  output logic        irq_joypad,
  output logic [7:0]  pressed_dbg
);

  btn_vec_t   raw_btn;
  btn_vec_t   stable_btn;
  logic [1:0] sel_q, sel_d;
  logic [3:0] line;
  logic [3:0] line_prev_q, line_prev_d;
  logic       irq_q, irq_d;
  logic       unused_bits;

  // Upper nibble is the action group, lower nibble the direction group,
  // each ordered to match readback lines 0..3.
  assign raw_btn = {snes_buttons[BTN_START], snes_buttons[BTN_SELECT],
                    snes_buttons[BTN_B],     snes_buttons[BTN_A],
                    snes_buttons[BTN_DOWN],  snes_buttons[BTN_UP],
                    snes_buttons[BTN_LEFT],  snes_buttons[BTN_RIGHT]};

  for (genvar i = 0; i < 8; i++) begin : g_btn
    gb_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .cpu_clock (cpu_clock),
      .rst       (rst),
      .raw_in    (raw_btn[i]),
      .stable_out(stable_btn[i])
    );
  end

  assign hit = (cpu_addr_bus == JOYP_ADDR);

  always_comb begin
    sel_d = sel_q;
    if (cpu_we && hit) begin
      sel_d = cpu_data_in[5:4];
    end
    // Active-low select: a deselected group forces its term to 1.
    line        = ({4{sel_q[1]}} | stable_btn[7:4]) & ({4{sel_q[0]}} | stable_btn[3:0]);
    line_prev_d = line;
    irq_d       = |(line_prev_q & ~line);
  end

  always_ff @(posedge cpu_clock) begin
    if (rst) begin
      sel_q       <= 2'b00;
      line_prev_q <= 4'hF;
      irq_q       <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      line_prev_q <= line_prev_d;
      irq_q       <= irq_d;
    end
  end

  assign data_out    = {2'b11, sel_q, line};
  assign irq_joypad  = irq_q;
  assign pressed_dbg = ~stable_btn;

  assign unused_bits = ^{snes_buttons[15:9], snes_buttons[1],
                         cpu_data_in[7:6], cpu_data_in[3:0]};

endmodule

// File: tb/tb_gb_joypad_regs.sv
// Directed bench for gb_joypad_regs with a short debounce window; expected
// values are queued on a scoreboard and popped when the DUT output is sampled.
module tb_gb_joypad_regs;

  logic        cpu_clock = 1'b0;
  logic        rst;
  logic [15:0] snes_buttons;
  logic [15:0] cpu_addr_bus;
  logic [7:0]  cpu_data_in;
  logic        cpu_we;
  logic        hit;
  logic [7:0]  data_out;
  logic        irq_joypad;
  logic [7:0]  pressed_dbg;

  typedef struct {
    string      tag;
    logic [7:0] value;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  gb_joypad_regs #(
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (4)
  ) dut (
    .cpu_clock   (cpu_clock),
    .rst         (rst),
    .snes_buttons(snes_buttons),
    .cpu_addr_bus(cpu_addr_bus),
    .cpu_data_in (cpu_data_in),
    .cpu_we      (cpu_we),
    .hit         (hit),
    .data_out    (data_out),
    .irq_joypad  (irq_joypad),
    .pressed_dbg (pressed_dbg)
  );

  always #5 cpu_clock = ~cpu_clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic sb_push(input string tag, input logic [7:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [7:0] observed);
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL %s: observed %02h but scoreboard is empty", tag, observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.value) else begin
        mismatched++;
        $error("FAIL %s: observed %02h expected %02h", e.tag, observed, e.value);
      end
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge cpu_clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] data_exp, input logic irq_exp);
    sb_push({tag, ".data_out"}, data_exp);
    sb_push({tag, ".irq"}, {7'b0, irq_exp});
    check({tag, ".data_out"}, data_out);
    check({tag, ".irq"}, {7'b0, irq_joypad});
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
    cpu_addr_bus = addr;
    cpu_data_in  = data;
    cpu_we       = 1'b1;
    #1;
    sb_push("write.hit", {7'b0, addr == 16'hFF00});
    check("write.hit", {7'b0, hit});
    tick();
    cpu_we       = 1'b0;
    cpu_addr_bus = 16'h0000;
    cpu_data_in  = 8'h00;
  endtask

  initial begin
    rst          = 1'b1;
    snes_buttons = 16'hFFFF;
    cpu_addr_bus = 16'h0000;
    cpu_data_in  = 8'h00;
    cpu_we       = 1'b0;

    // Reset with everything released.
    tick();
    tick();
    rst = 1'b0;
    chk_out("reset", 8'hCF, 1'b0);
    sb_push("reset.pressed_dbg", 8'h00);
    check("reset.pressed_dbg", pressed_dbg);

    // Select the action group, then press A: line 0 falls 10 cycles later.
    cpu_write(16'hFF00, 8'h10);
    chk_out("sel_action", 8'hDF, 1'b0);
    snes_buttons[8] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_out("a_press", (k >= 10) ? 8'hDE : 8'hDF, k == 11);
    end
    sb_push("a_press.pressed_dbg", 8'h10);
    check("a_press.pressed_dbg", pressed_dbg);

    // Release A: rising edge never fires.
    snes_buttons[8] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_out("a_release", (k >= 10) ? 8'hDF : 8'hDE, 1'b0);
    end

    // 5-cycle glitch on A never reaches the stable level.
    snes_buttons[8] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_out("glitch_low", 8'hDF, 1'b0);
    end
    snes_buttons[8] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_out("glitch_after", 8'hDF, 1'b0);
    end

    // Hold Up while only the action group is selected, then select direction.
    snes_buttons[4] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_out("up_hidden", 8'hDF, 1'b0);
    end
    cpu_write(16'hFF00, 8'h20);
    chk_out("sel_dir", 8'hEB, 1'b0);
    tick();
    chk_out("sel_dir_irq", 8'hEB, 1'b1);
    tick();
    chk_out("sel_dir_after", 8'hEB, 1'b0);

    snes_buttons[4] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_out("up_release", (k >= 10) ? 8'hEF : 8'hEB, 1'b0);
    end

    // Both groups selected: A and Right share line 0.
    cpu_write(16'hFF00, 8'h00);
    chk_out("sel_both", 8'hCF, 1'b0);
    snes_buttons[8] = 1'b0;
    snes_buttons[7] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_out("a_right", (k >= 10) ? 8'hCE : 8'hCF, k == 11);
    end
    sb_push("a_right.pressed_dbg", 8'h11);
    check("a_right.pressed_dbg", pressed_dbg);
    snes_buttons[8] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_out("a_only_release", 8'hCE, 1'b0);
    end
    sb_push("right_only.pressed_dbg", 8'h01);
    check("right_only.pressed_dbg", pressed_dbg);

    // Write to a neighbouring address leaves sel alone.
    cpu_write(16'hFF01, 8'hFF);
    chk_out("other_addr", 8'hCE, 1'b0);

    // Press B, reset mid-debounce with a coinciding write, then re-qualify.
    snes_buttons[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_out("b_partial", 8'hCE, 1'b0);
    end
    rst          = 1'b1;
    cpu_addr_bus = 16'hFF00;
    cpu_data_in  = 8'h30;
    cpu_we       = 1'b1;
    tick();
    rst          = 1'b0;
    cpu_we       = 1'b0;
    cpu_addr_bus = 16'h0000;
    cpu_data_in  = 8'h00;
    chk_out("mid_reset", 8'hCF, 1'b0);
    sb_push("mid_reset.pressed_dbg", 8'h00);
    check("mid_reset.pressed_dbg", pressed_dbg);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_out("requalify", (k >= 10) ? 8'hCC : 8'hCF, k == 11);
    end
    sb_push("requalify.pressed_dbg", 8'h21);
    check("requalify.pressed_dbg", pressed_dbg);

    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
